// File: rtl/gctr_64.sv
// Counter-mode keystream stage: an iterative PRESENT-80 core encrypts an internal
// counter block and XORs the result into data_in, one block every 33 cycles.
module gctr_64 (
   input  logic        clk,
   input  logic        reset,
   input  logic [63:0] data_in,
   input  logic [79:0] key,
   output logic [63:0] data_out
);

   localparam logic [5:0] LAST_ROUND = 6'd32;

   logic [63:0] cb_r, cb_s;
   logic [63:0] data_r, data_s;
   logic [63:0] state_r, state_s;
   logic [79:0] key_r, key_s;
   logic [5:0]  round_r, round_s;
   logic [63:0] dout_r, dout_s;

   function automatic logic [3:0] sbox4(input logic [3:0] x);
      logic [3:0] y;
      case (x)
         4'h0: y = 4'hC;
         4'h1: y = 4'h5;
         4'h2: y = 4'h6;
         4'h3: y = 4'hB;
         4'h4: y = 4'h9;
         4'h5: y = 4'h0;
         4'h6: y = 4'hA;
         4'h7: y = 4'hD;
         4'h8: y = 4'h3;
         4'h9: y = 4'hE;
         4'hA: y = 4'hF;
         4'hB: y = 4'h8;
         4'hC: y = 4'h4;
         4'hD: y = 4'h7;
         4'hE: y = 4'h1;
         4'hF: y = 4'h2;
         default: y = 4'h0;
      endcase
      return y;
   endfunction

   function automatic logic [63:0] s_layer(input logic [63:0] x);
      logic [63:0] o;
      o = 64'h0;
      for (int n = 0; n < 16; n++) begin
         o[4*n +: 4] = sbox4(x[4*n +: 4]);
      end
      return o;
   endfunction

   // Bit 63 is a fixed point of the permutation, so it keeps its value from the copy.
   function automatic logic [63:0] p_layer(input logic [63:0] x);
      logic [63:0] o;
      o = x;
      for (int i = 0; i < 63; i++) begin
         o[(16*i) % 63] = x[i];
      end
      return o;
   endfunction

   function automatic logic [79:0] key_update(input logic [79:0] k, input logic [4:0] r);
      logic [79:0] t;
      t          = {k[18:0], k[79:19]};
      t[79:76]   = sbox4(t[79:76]);
      t[19:15]   = t[19:15] ^ r;
      return t;
   endfunction

   // Phase sequencing: capture at round 0, cipher rounds 1..31, output/increment at 32.
   always_comb begin
      cb_s    = cb_r;
      data_s  = data_r;
      state_s = state_r;
      key_s   = key_r;
      round_s = round_r;
      dout_s  = dout_r;
      case (round_r)
         6'd0: begin
            data_s  = data_in;
            key_s   = key;
            state_s = cb_r;
            round_s = 6'd1;
         end
         LAST_ROUND: begin
            dout_s  = data_r ^ state_r ^ key_r[79:16];
            cb_s    = {cb_r[63:32], cb_r[31:0] + 32'd1};
            round_s = 6'd0;
         end
         default: begin
            if (round_r < LAST_ROUND) begin
               state_s = p_layer(s_layer(state_r ^ key_r[79:16]));
               key_s   = key_update(key_r, round_r[4:0]);
               round_s = round_r + 6'd1;
            end else begin
               round_s = 6'd0;
            end
         end
      endcase
   end

   // State registers with asynchronous clear.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cb_r    <= 64'h0;
         data_r  <= 64'h0;
         state_r <= 64'h0;
         key_r   <= 80'h0;
         round_r <= 6'd0;
         dout_r  <= 64'h0;
      end else begin
         cb_r    <= cb_s;
         data_r  <= data_s;
         state_r <= state_s;
         key_r   <= key_s;
         round_r <= round_s;
         dout_r  <= dout_s;
      end
   end

   assign data_out = dout_r;

endmodule

// File: tb/tb_gctr_64.sv
// Scoreboard bench for gctr_64: stimulus queues expected words, a negedge monitor
// compares at every finish edge and checks data_out is held everywhere else.
module tb_gctr_64;

   logic        clk = 1'b0;
   logic        reset;
   logic [63:0] data_in;
   logic [79:0] key;
   logic [63:0] data_out;

   int          n_vec = 0;
   int          n_bad = 0;
   int          edge_cnt;
   logic [63:0] held = 64'h0;
   logic [63:0] exp_q[$];
   string       name_q[$];

   localparam logic [79:0] K_ONES = 80'hFFFFFFFFFFFFFFFFFFFF;
   localparam logic [79:0] K_RT   = 80'h3014f4d8c37d9cc7e689;
   localparam logic [63:0] D_RT   = 64'h834349fd8e99a23b;

   always #5 clk = ~clk;

   gctr_64 dut (
      .clk      (clk),
      .reset    (reset),
      .data_in  (data_in),
      .key      (key),
      .data_out (data_out)
   );

   function automatic logic [63:0] present80(input logic [79:0] k, input logic [63:0] pt);
      logic [63:0] tab;
      logic [63:0] s, t;
      logic [79:0] kr;
      logic [4:0]  rc;
      tab = 64'h21748FE3DA09B65C;
      s   = pt;
      kr  = k;
      for (int r = 1; r <= 31; r++) begin
         s = s ^ kr[79:16];
         for (int n = 0; n < 16; n++) begin
            t[4*n +: 4] = tab[4*s[4*n +: 4] +: 4];
         end
         s = t;
         t[63] = s[63];
         for (int i = 0; i < 63; i++) begin
            t[(16*i) % 63] = s[i];
         end
         s = t;
         kr = {kr[18:0], kr[79:19]};
         kr[79:76] = tab[4*kr[79:76] +: 4];
         rc = r[4:0];
         kr[19:15] = kr[19:15] ^ rc;
      end
      return s ^ kr[79:16];
   endfunction

   task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk or negedge reset) begin
      if (!reset) edge_cnt <= 0;
      else        edge_cnt <= edge_cnt + 1;
   end

   // Monitor: finish edges pop the scoreboard, all other cycles must hold the last value.
   always @(negedge clk) begin
      if (reset !== 1'b1) begin
         held = 64'h0;
         check("reset_hold", data_out, 64'h0);
      end else if (edge_cnt != 0 && edge_cnt % 33 == 0) begin
         if (exp_q.size() == 0) begin
            n_vec++;
            n_bad++;
            $display("FAIL unexpected_finish: got %h with no expected word", data_out);
         end else begin
            held = exp_q.pop_front();
            check(name_q.pop_front(), data_out, held);
         end
      end else begin
         check("stable", data_out, held);
      end
   end

   task automatic do_block(input logic [63:0] d, input logic [79:0] k,
                           input logic [63:0] exp, input string nm, input bit disturb);
      data_in = d;
      key     = k;
      exp_q.push_back(exp);
      name_q.push_back(nm);
      if (!reset) begin
         #2 reset = 1'b1;
      end
      for (int i = 1; i <= 33; i++) begin
         @(negedge clk);
         if (disturb && i < 33) begin
            data_in = {$urandom, $urandom};
            key     = {$urandom, $urandom, $urandom};
         end
      end
   endtask

   task automatic apply_reset();
      #2 reset = 1'b0;
      #1 check("reset_async", data_out, 64'h0);
      repeat (3) @(negedge clk);
   endtask

   initial begin
      logic [63:0] fb;
      reset   = 1'b0;
      data_in = 64'hDEADBEEFCAFEF00D;
      key     = 80'h0123456789ABCDEF0123;
      repeat (4) @(negedge clk);

      do_block(64'h0, 80'h0, 64'h5579C1387B228445, "kat_zero", 1'b0);
      do_block(64'h0, 80'h0, present80(80'h0, 64'h1), "ctr_advance", 1'b0);

      data_in = 64'h0123456789ABCDEF;
      key     = K_ONES;
      repeat (10) @(negedge clk);
      @(posedge clk);
      #2 reset = 1'b0;
      #1 check("abort_clear", data_out, 64'h0);
      repeat (3) @(negedge clk);

      do_block(64'h0, K_ONES, 64'hE72C46C0F5945049, "kat_ones", 1'b0);
      apply_reset();
      do_block(64'hFFFFFFFFFFFFFFFF, K_ONES, 64'h18D3B93F0A6BAFB6, "kat_ones_inv", 1'b0);

      apply_reset();
      do_block(D_RT, K_RT, D_RT ^ present80(K_RT, 64'h0), "rt_forward", 1'b0);
      fb = data_out;
      apply_reset();
      do_block(fb, K_RT, D_RT, "rt_back", 1'b0);

      apply_reset();
      do_block(D_RT, K_RT, D_RT ^ present80(K_RT, 64'h0), "isolation", 1'b1);

      repeat (5) @(negedge clk);
      n_vec++;
      if (exp_q.size() != 0) begin
         n_bad++;
         $display("FAIL pending: got %0d unchecked words expected 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/gctr_64.md
# gctr_64

GCTR (counter-mode) keystream engine for a 64-bit block cipher. An iterative PRESENT-80 core encrypts an internal counter block, and the result is XORed with the input word to produce the output word. It sits in the GCM datapath as the encrypt/decrypt stage; encryption and decryption are the same operation. One block is processed every 33 clock cycles, continuously, while out of reset.

## Interface
- No parameters.
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-low reset: 0 clears all state immediately, 1 runs.
- data_in  input  64  plaintext or ciphertext word; sampled once per block at the capture edge.
- key  input  80  PRESENT-80 key; sampled once per block at the capture edge.
- data_out  output  64  `data_in ^ PRESENT80(key, CB)` for the most recently completed block; held between updates.

## Operation
- Internal registers:
  - `cb[63:0]`: counter block.
  - `data_reg[63:0]`, `state[63:0]`, `key_reg[79:0]`.
  - `round[5:0]`: phase counter, 0..32.
- Initial counter block is ICB = 64'h0. After each block, `cb[31:0]` increments mod 2^32 (inc32); `cb[63:32]` is unchanged.
- Round key K_r = `key_reg[79:16]`.
- PRESENT round: `state <= P(S(state ^ K_r))`.
  - S applies the 4-bit S-box C,5,6,B,9,0,A,D,3,E,F,8,4,7,1,2 (input 0..F) to all 16 nibbles.
  - P moves bit i to position (16*i) mod 63 for i < 63; bit 63 stays in place.
- Key update after using K_r:
  1. Rotate `key_reg` left by 61.
  2. Pass bits [79:76] through S.
  3. Set bits [19:15] ^= r (5-bit round number).
- Phase sequence, driven by `round`:
  - **round = 0 (capture):** `data_reg <= data_in`, `key_reg <= key`, `state <= cb`, `round <= 1`.
  - **round = 1..31:** apply round r with K_r, update `key_reg` with r, `round <= round + 1`.
  - **round = 32 (finish):** `data_out <= data_reg ^ state ^ key_reg[79:16]` (K_32), `cb[31:0] <= cb[31:0] + 1`, `round <= 0`.
- Changes on `data_in` or `key` outside the capture edge do not affect the block in flight.

## Timing
- Reset (reset = 0, asynchronous): `data_out`, `cb`, `data_reg`, `state`, `key_reg` and `round` all become 0. `data_out` reads 64'h0 while in reset.
- The first rising edge with reset = 1 is the capture edge E0. Rounds occur on E1..E31, and `data_out` updates on E32.
  - Latency from capture to valid output: 32 cycles.
  - Block period: 33 cycles. The next capture is at E33.
- `data_out` changes only on a finish edge or on reset. Otherwise it is stable.
- Reset asserted mid-block aborts the block: `data_out` stays 0 and `cb` returns to 0. After release, processing restarts at a new capture edge with ICB.
- Counter wrap: `cb[31:0]` = FFFFFFFF increments to 00000000 with no carry into `cb[63:32]`.
- No handshake. The upstream block must present each data word at its capture edge (every 33rd cycle after reset release).

## Test plan
- **Reset:** hold reset = 0 with arbitrary inputs, then assert reset low mid-block -> `data_out` = 0 immediately and stays 0.
- **Known answer, zero key:** release reset with key = 0 and data_in = 0 -> after E32, `data_out` = 5579C1387B228445.
- **Known answer, all-ones key:** key = FFFFFFFFFFFFFFFFFFFF, data_in = 0 -> `data_out` = E72C46C0F5945049. With data_in = FFFFFFFFFFFFFFFF -> `data_out` = 18D3B93F0A6BAFB6.
- **Counter advance:** key = 0, data_in = 0 for two blocks -> block 1 output = PRESENT(0, 0) = 5579C1387B228445; block 2 output = PRESENT(0, 1), checked against a reference model; block 2 appears on the 66th edge after release.
- **Round trip:** feed block 1's `data_out` back as data_in after a reset with the same key -> recovered `data_out` equals the original data_in (e.g. 834349fd8e99a23b, key 3014f4d8c37d9cc7e689).
- **Input isolation:** toggle `data_in` and `key` during E1..E32 -> output identical to the undisturbed run.
